xor_parity_rx: RTL and testbench

- Serial frame receiver: the checking end of the XOR parity link.
- Deserialises one frame per transfer: start bit, DATA_W data bits LSB first, one parity bit, one stop bit.
- Recomputes parity with an XOR accumulator and flags parity and framing errors.
- Sits behind a bit-strobe source (bit_vld); feeds a parallel consumer via a one-cycle data_vld pulse.

---
 rtl/xor_parity_rx.sv | 133 +++++++++++++
 tb/tb_xor_parity_rx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_parity_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, parity bit, stop bit.
// Optional mid-frame idle timeout is enabled by defining RX_TIMEOUT_EN.
module xor_parity_rx #(
  parameter int DATA_W      = 8,
  parameter int ODD_PARITY  = 0,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_vld,
  output logic [DATA_W-1:0] data_out,
  output logic              data_vld,
  output logic              parity_err,
  output logic              frame_err,
  output logic              timeout_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic             ODD      = (ODD_PARITY != 0);

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  cnt;
  logic              acc;
  logic              p_err;
  logic [DATA_W-1:0] shreg;
  logic              timeout_hit;

`ifdef RX_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] idle_cnt;

  // The abort fires on the TIMEOUT_CYC-th consecutive strobe-less busy cycle.
  assign timeout_hit = busy && !bit_vld && (idle_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
      if (bit_vld || !busy || timeout_hit)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign timeout_err    = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (timeout_hit) begin
      next_state = IDLE;
    end else if (bit_vld) begin
      case (state)
        IDLE:    if (!bit_in) next_state = DATA;
        DATA:    if (cnt == LAST_BIT) next_state = PARITY;
        PARITY:  next_state = STOP;
        STOP:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // A frame is always delivered at the stop strobe; its status flags describe that frame only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      acc        <= 1'b0;
      p_err      <= 1'b0;
      shreg      <= '0;
      data_out   <= '0;
      data_vld   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_vld <= 1'b0;
      if (bit_vld) begin
        case (state)
          IDLE: begin
            if (!bit_in) begin
              cnt   <= '0;
              acc   <= 1'b0;
              shreg <= '0;
            end
          end
          DATA: begin
            shreg[cnt] <= bit_in;
            acc        <= acc ^ bit_in;
            cnt        <= cnt + 1'b1;
          end
          PARITY: begin
            p_err <= acc ^ bit_in ^ ODD;
          end
          STOP: begin
            data_out   <= shreg;
            parity_err <= p_err;
            frame_err  <= ~bit_in;
            data_vld   <= 1'b1;
          end
          default: begin
            cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xor_parity_rx.sv
// Self-checking bench for xor_parity_rx: even and odd parity instances share one line,
// a frame-level model is compared every cycle and literal per-frame expectations are queued.
module tb_xor_parity_rx;

  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          bit_in  = 1'b1;
  logic          bit_vld = 1'b0;

  logic [DW-1:0] data_out;
  logic          data_vld;
  logic          parity_err;
  logic          frame_err;
  logic          timeout_err;
  logic          busy;

  logic [DW-1:0] data_out_o;
  logic          data_vld_o;
  logic          parity_err_o;
  logic          frame_err_o;
  logic          timeout_err_o;
  logic          busy_o;

  int pass_cnt  = 0;
  int check_cnt = 0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          pe;
    logic          fe;
  } exp_t;

  exp_t exp_q[$];

  int            pos       = 0;
  int            idle_run  = 0;
  logic [DW-1:0] word      = '0;
  logic          pbit      = 1'b0;
  logic [DW-1:0] exp_data  = '0;
  logic          exp_perr  = 1'b0;
  logic          exp_perro = 1'b0;
  logic          exp_ferr  = 1'b0;
  logic          exp_vld   = 1'b0;
  logic          exp_to    = 1'b0;

  xor_parity_rx #(.DATA_W(DW), .ODD_PARITY(0), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld),
    .data_out(data_out), .data_vld(data_vld), .parity_err(parity_err),
    .frame_err(frame_err), .timeout_err(timeout_err), .busy(busy)
  );

  xor_parity_rx #(.DATA_W(DW), .ODD_PARITY(1), .TIMEOUT_CYC(TO)) dut_odd (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld),
    .data_out(data_out_o), .data_vld(data_vld_o), .parity_err(parity_err_o),
    .frame_err(frame_err_o), .timeout_err(timeout_err_o), .busy(busy_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp)
      pass_cnt++;
    else
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
  endtask

  // Frame-level view of the line: position 1..DW data, DW+1 parity, DW+2 stop.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pos      <= 0;
      idle_run <= 0;
      word     <= '0;
      pbit     <= 1'b0;
      exp_data <= '0;
      exp_perr <= 1'b0;
      exp_perro <= 1'b0;
      exp_ferr <= 1'b0;
      exp_vld  <= 1'b0;
      exp_to   <= 1'b0;
    end else begin
      exp_vld <= 1'b0;
      exp_to  <= 1'b0;
      if (bit_vld) begin
        idle_run <= 0;
        if (pos == 0) begin
          if (!bit_in) begin
            pos  <= 1;
            word <= '0;
          end
        end else if (pos <= DW) begin
          word[pos-1] <= bit_in;
          pos         <= pos + 1;
        end else if (pos == DW + 1) begin
          pbit <= bit_in;
          pos  <= pos + 1;
        end else begin
          exp_data  <= word;
          exp_perr  <= (^word) ^ pbit;
          exp_perro <= ~((^word) ^ pbit);
          exp_ferr  <= ~bit_in;
          exp_vld   <= 1'b1;
          pos       <= 0;
        end
      end
`ifdef RX_TIMEOUT_EN
      else if (pos != 0) begin
        if (idle_run == TO - 1) begin
          pos      <= 0;
          idle_run <= 0;
          exp_to   <= 1'b1;
        end else begin
          idle_run <= idle_run + 1;
        end
      end
`endif
    end
  end

  always @(negedge clk) begin
    exp_t e;
    checkOutput("data_vld",    32'(data_vld),    32'(exp_vld));
    checkOutput("data_out",    32'(data_out),    32'(exp_data));
    checkOutput("parity_err",  32'(parity_err),  32'(exp_perr));
    checkOutput("frame_err",   32'(frame_err),   32'(exp_ferr));
    checkOutput("busy",        32'(busy),        32'(pos != 0));
    checkOutput("timeout_err", 32'(timeout_err), 32'(exp_to));
    checkOutput("odd_data_vld",   32'(data_vld_o),   32'(exp_vld));
    checkOutput("odd_data_out",   32'(data_out_o),   32'(exp_data));
    checkOutput("odd_parity_err", 32'(parity_err_o), 32'(exp_perro));
    checkOutput("odd_frame_err",  32'(frame_err_o),  32'(exp_ferr));
    checkOutput("odd_busy",       32'(busy_o),       32'(pos != 0));
    if (data_vld) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_data_vld", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("lit_data",       32'(data_out),   32'(e.d));
        checkOutput("lit_parity_err", 32'(parity_err), 32'(e.pe));
        checkOutput("lit_frame_err",  32'(frame_err),  32'(e.fe));
      end
    end
  end

  task automatic applyStimulus(input logic b, input int gap);
    repeat (gap) begin
      @(negedge clk);
      bit_vld = 1'b0;
      bit_in  = 1'b1;
    end
    @(negedge clk);
    bit_in  = b;
    bit_vld = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bit_vld = 1'b0;
      bit_in  = 1'b1;
    end
  endtask

  function automatic int pickGap(input int maxgap);
    if (maxgap == 0) return 0;
    return int'($urandom_range(maxgap, 0));
  endfunction

  task automatic sendFrame(input logic [DW-1:0] d, input logic p, input logic s, input int maxgap);
    applyStimulus(1'b0, pickGap(maxgap));
    for (int i = 0; i < DW; i++) applyStimulus(d[i], pickGap(maxgap));
    applyStimulus(p, pickGap(maxgap));
    applyStimulus(s, pickGap(maxgap));
  endtask

  task automatic pushExpect(input logic [DW-1:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d  = d;
    e.pe = pe;
    e.fe = fe;
    exp_q.push_back(e);
  endtask

  task automatic resetPulse();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_busy",     32'(busy),     32'd0);
    checkOutput("rst_data_out", 32'(data_out), 32'd0);
    checkOutput("rst_data_vld", 32'(data_vld), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("init_data_out",   32'(data_out),   32'd0);
    checkOutput("init_busy",       32'(busy),       32'd0);
    checkOutput("init_parity_err", 32'(parity_err), 32'd0);
    checkOutput("init_frame_err",  32'(frame_err),  32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    idle(2);

    // Even parity 0xA5, correct parity and stop.
    pushExpect(8'hA5, 1'b0, 1'b0);
    sendFrame(8'hA5, 1'b0, 1'b1, 0);
    @(negedge clk);
    checkOutput("a5_vld_latency", 32'(data_vld), 32'd1);
    bit_vld = 1'b0;
    idle(1);
    checkOutput("a5_busy_after", 32'(busy), 32'd0);
    checkOutput("a5_data_out", 32'(data_out), 32'hA5);
    checkOutput("a5_odd_perr", 32'(parity_err_o), 32'd1);

    // 0x01 with parity 0: mismatch for even, match for odd.
    pushExpect(8'h01, 1'b1, 1'b0);
    sendFrame(8'h01, 1'b0, 1'b1, 0);
    idle(2);
    checkOutput("x01_perr", 32'(parity_err), 32'd1);
    checkOutput("x01_odd_perr", 32'(parity_err_o), 32'd0);

    // 0x3C with a zero stop bit, then a line of ones must not start a frame.
    pushExpect(8'h3C, 1'b0, 1'b1);
    sendFrame(8'h3C, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 0);
    idle(1);
    checkOutput("x3c_frame_err", 32'(frame_err), 32'd1);
    checkOutput("x3c_idle_busy", 32'(busy), 32'd0);

    // Gapped 0x5A followed immediately by 0xC3.
    pushExpect(8'h5A, 1'b0, 1'b0);
    pushExpect(8'hC3, 1'b0, 1'b0);
    sendFrame(8'h5A, 1'b0, 1'b1, 7);
    sendFrame(8'hC3, 1'b0, 1'b1, 0);
    idle(2);
    checkOutput("c3_data_out", 32'(data_out), 32'hC3);

    // Reset after start plus four data bits, then 0x96.
    applyStimulus(1'b0, 0);
    applyStimulus(1'b1, 0);
    applyStimulus(1'b0, 0);
    applyStimulus(1'b1, 0);
    applyStimulus(1'b1, 0);
    idle(1);
    checkOutput("mid_busy", 32'(busy), 32'd1);
    resetPulse();
    pushExpect(8'h96, 1'b0, 1'b0);
    sendFrame(8'h96, 1'b0, 1'b1, 2);
    idle(2);
    checkOutput("x96_data_out", 32'(data_out), 32'h96);

    // Start plus three data bits, then a long silence.
    applyStimulus(1'b0, 0);
    applyStimulus(1'b1, 0);
    applyStimulus(1'b1, 0);
    applyStimulus(1'b0, 0);
    idle(TO + 4);
`ifdef RX_TIMEOUT_EN
    checkOutput("to_busy", 32'(busy), 32'd0);
    checkOutput("to_data_kept", 32'(data_out), 32'h96);
`else
    checkOutput("to_busy_stuck", 32'(busy), 32'd1);
    checkOutput("to_err_tied", 32'(timeout_err), 32'd0);
`endif
    resetPulse();
    idle(3);

    checkOutput("expect_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
